// File: rtl/imem_boot_loader.sv
// Boot loader: receives a counted, XOR-checksummed byte stream, writes it into instruction
// memory word by word, and holds the core in reset until a valid image is in place.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        StCntHi,
        StCntLo,
        StData,
        StCsum,
        StRun,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_hi_q, cnt_hi_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] shift_q, shift_d;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] words_q, words_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept;
    logic        restart;
    logic [15:0] count_rx;
    logic        count_over;
    logic        count_zero;
    logic [15:0] words_inc;
    logic        word_end;
    logic        last_word;
    logic        csum_ok;

    assign accept     = rx_valid && rx_ready;
    assign restart    = reload && (state_q == StRun || state_q == StErr);
    assign count_rx   = {cnt_hi_q, rx_data};
    assign count_over = 32'(count_rx) > MAX_WORDS;
    assign count_zero = (count_rx == 16'd0);
    assign words_inc  = words_q + 16'd1;
    assign word_end   = (byte_idx_q == 2'd3);
    assign last_word  = (words_inc == count_q);
    assign csum_ok    = (rx_data == acc_q);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StCntHi;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCntHi: begin
                if (accept) state_d = StCntLo;
            end
            StCntLo: begin
                if (accept) begin
                    if (count_over) begin
                        state_d = StErr;
                    end else if (count_zero) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept && word_end && last_word) state_d = StCsum;
            end
            StCsum: begin
                if (accept) state_d = csum_ok ? StRun : StErr;
            end
            StRun, StErr: begin
                if (reload) state_d = StCntHi;
            end
            default: state_d = StCntHi;
        endcase
    end

    // Output logic: a reload pulse blocks the handshake so no byte is swallowed
    always_comb begin
        rx_ready = 1'b0;
        unique case (state_q)
            StCntHi, StCntLo, StData, StCsum: rx_ready = !reload;
            default:                          rx_ready = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_hi_d    = cnt_hi_q;
        count_d     = count_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        words_d     = words_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        if (restart) begin
            cpu_reset_d = 1'b1;
            done_d      = 1'b0;
            error_d     = 1'b0;
            words_d     = 16'd0;
            acc_d       = 8'd0;
            byte_idx_d  = 2'd0;
        end else if (accept) begin
            case (state_q)
                StCntHi: cnt_hi_d = rx_data;
                StCntLo: begin
                    count_d    = count_rx;
                    byte_idx_d = 2'd0;
                    if (count_over) error_d = 1'b1;
                end
                StData: begin
                    acc_d      = acc_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (word_end) begin
                        wdata_d = {shift_q, rx_data};
                        addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
                        we_d    = 1'b1;
                        words_d = words_inc;
                    end else begin
                        shift_d = {shift_q[15:0], rx_data};
                    end
                end
                StCsum: begin
                    if (csum_ok) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_hi_q    <= 8'd0;
            count_q     <= 16'd0;
            byte_idx_q  <= 2'd0;
            shift_q     <= 24'd0;
            acc_q       <= 8'd0;
            words_q     <= 16'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            cnt_hi_q    <= cnt_hi_d;
            count_q     <= count_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            words_q     <= words_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad/overflow/empty images, gaps, reset and reload.
module tb_imem_boot_loader;

    typedef logic [7:0] byte_q_t [$];

    logic        clock;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];

    imem_boot_loader #(
        .MAX_WORDS(256),
        .BASE_ADDR(32'h0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .reload      (reload),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset   (cpu_reset),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        check_eq("handshake_timeout", 32'(waited < 50), 32'd1);
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_stream(input byte_q_t s, input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps ? int'($urandom_range(0, 3)) : 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_two_writes(input string tag);
        check_eq({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check_eq({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
            check_eq({tag, "_data0"}, wr_data[0], 32'h2008_0005);
            check_eq({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
            check_eq({tag, "_data1"}, wr_data[1], 32'h2009_000A);
        end
    endtask

    task automatic pulse_reload();
        @(negedge clock);
        reload = 1'b1;
        @(posedge clock);
        #1 reload = 1'b0;
    endtask

    byte_q_t good_img;
    byte_q_t bad_img;

    initial begin
        good_img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                     8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        bad_img  = good_img;
        bad_img[10] = 8'h0F;

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        reload   = 1'b0;
        repeat (2) @(negedge clock);

        // Reset values
        check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rst_imem_we", 32'(imem_we), 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'd0);
        check_eq("rst_imem_wdata", imem_wdata, 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);

        // Good image
        clear_writes();
        send_stream(good_img, 1'b0);
        check_two_writes("good");
        check_eq("good_done", 32'(done), 32'd1);
        check_eq("good_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("good_words", 32'(words_loaded), 32'd2);
        check_eq("good_error", 32'(error), 32'd0);
        check_eq("good_rx_ready", 32'(rx_ready), 32'd0);

        // Reload together with rx_valid in RUN: byte must not be consumed
        @(negedge clock);
        reload   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        #1 check_eq("reload_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clock);
        #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        check_eq("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("reload_done", 32'(done), 32'd0);
        check_eq("reload_words", 32'(words_loaded), 32'd0);

        // Second image (bad checksum) lands at BASE_ADDR again
        clear_writes();
        send_stream(bad_img, 1'b0);
        check_two_writes("bad");
        check_eq("bad_error", 32'(error), 32'd1);
        check_eq("bad_done", 32'(done), 32'd0);
        check_eq("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("bad_rx_ready", 32'(rx_ready), 32'd0);

        // Count overflow: 0x0101 > 256
        pulse_reload();
        check_eq("ovf_error_cleared", 32'(error), 32'd0);
        clear_writes();
        send_stream('{8'h01, 8'h01}, 1'b0);
        check_eq("ovf_error", 32'(error), 32'd1);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        #1 check_eq("ovf_rx_ready", 32'(rx_ready), 32'd0);
        repeat (4) @(negedge clock);
        rx_valid = 1'b0;
        check_eq("ovf_nwr", 32'(wr_addr.size()), 32'd0);
        check_eq("ovf_words", 32'(words_loaded), 32'd0);

        // Empty image
        pulse_reload();
        clear_writes();
        send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
        check_eq("empty_done", 32'(done), 32'd1);
        check_eq("empty_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("empty_nwr", 32'(wr_addr.size()), 32'd0);

        // Good image with random valid gaps
        pulse_reload();
        clear_writes();
        send_stream(good_img, 1'b1);
        check_two_writes("gaps");
        check_eq("gaps_done", 32'(done), 32'd1);
        check_eq("gaps_words", 32'(words_loaded), 32'd2);

        // Asynchronous reset after 6 bytes of a fresh load
        pulse_reload();
        for (int i = 0; i < 6; i++) send_byte(good_img[i], 0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("midrst_imem_we", 32'(imem_we), 32'd0);
        check_eq("midrst_imem_addr", imem_addr, 32'd0);
        check_eq("midrst_imem_wdata", imem_wdata, 32'd0);
        check_eq("midrst_words", 32'(words_loaded), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        clear_writes();
        send_stream(good_img, 1'b0);
        check_two_writes("fresh");
        check_eq("fresh_done", 32'(done), 32'd1);
        check_eq("fresh_cpu_reset", 32'(cpu_reset), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
